isqrt_engine: RTL
=================

# isqrt_engine

Sequential digit-by-digit integer square root unit placed directly upstream of the prime number detector. It accepts an unsigned operand on a start/ready handshake and computes floor(sqrt(operand)) one result bit per clock, together with the remainder and a perfect-square flag. It then holds a level `valid` that the detector consumes as its enable, replacing the fixed-rate square root stage in the prime detection chain.

## Interface
- `WIDTH`, default 32: operand width; must be even and ≥ 4.
- `clk`  input  1  rising-edge clock (the divided square-root clock at top level).
- `reset`  input  1  asynchronous, active-low reset.
- `start`  input  1  request; sampled only when `ready`=1.
- `operand`  input  WIDTH  unsigned value; captured on the accepted `start`.
- `ready`  output  1  high in IDLE and HOLD.
- `valid`  output  1  level; results stable and final.
- `root`  output  WIDTH/2  floor(sqrt(operand)).
- `remainder`  output  WIDTH/2+1  operand − root².
- `is_square`  output  1  remainder == 0, qualified by `valid`.

## Operation
- States: IDLE, CALC, HOLD.
- IDLE/HOLD with `start`=1: capture operand, clear rem/root accumulators, deassert `valid`, load iteration index `i`, go to CALC.
- CALC, one iteration per edge, for pair index i:
  - rem' = (rem<<2) | op[2i+1:2i];
  - trial = (root<<2) | 1;
  - if rem' ≥ trial: rem = rem' − trial, root = (root<<1)|1;
  - else: rem = rem', root = root<<1.
- Internal rem is WIDTH/2+2 bits; unsigned compare; no wrap is possible because the final rem ≤ 2·root.
- On the iteration with i = 0: latch outputs, set `valid`, go to HOLD. Otherwise decrement i.
- HOLD: outputs and `valid` are held indefinitely until the next accepted `start`.
- `start` during CALC is ignored; there is no queueing. `operand` changes outside the capture edge have no effect.
- `root`/`remainder`/`is_square` update only on the completion edge; they never show partial values.
- Reset, including mid-CALC: state IDLE, `ready`=1, `valid`=0, `root`=0, `remainder`=0, `is_square`=0, and the in-flight operation is discarded.

## Timing
- Accept edge E0 (`start`·`ready`). Iterations run on E1..E(k).
- `valid` rises after E(k); `ready` drops after E0 and rises after E(k).
- Without early exit, k = WIDTH/2 (16 for the default width).
- A new `start` on the same edge `valid` is seen high is accepted. `valid` falls after that edge.
- Throughput: one result per k+1 cycles when `start` is held high.

## Configuration
- `ISQRT_EARLY_EXIT_EN`: when defined, E0 loads i = index of the highest nonzero 2-bit pair of the operand (0 if the operand is 0), so k = i+1.
  - Results are bit-identical to the non-macro build; only latency changes.
- Undefined: i = WIDTH/2−1 always, giving fixed latency.

## Structure
- Package `isqrt_pkg`:
  - state enum (IDLE, CALC, HOLD);
  - `ISQRT_DEF_WIDTH`=32;
  - width helper localparams (root width WIDTH/2, remainder width WIDTH/2+1).
- One sub-module, `isqrt_step`: purely combinational single iteration (rem, root, operand pair in → rem, root out), instantiated once in the datapath.
- Leading-pair priority encoder: inline, and present only under the macro.

## Test plan
- operand 4294967291 → root 65535, remainder 131066, is_square 0, `valid` after exactly 16 cycles (both builds, since the top pair is nonzero).
- operand 49 → root 7, remainder 0, is_square 1; latency 16 without the macro, 3 with `ISQRT_EARLY_EXIT_EN`.
- operand 0 → root 0, remainder 0, is_square 1; latency 16 without the macro, 1 with it.
- operand 0xFFFFFFFF → root 65535, remainder 131070 (maximum remainder; no overflow).
- `reset` asserted at cycle 8 of a CALC on 1000000 → all outputs 0 and `ready`=1 asynchronously. A fresh start then yields root 1000, remainder 0.
- `start` pulsed in mid-CALC with operand 16 is ignored (the result is still that of the first operand). `start` held across HOLD with operand 144 then 145 gives back-to-back results 12/0/1 and 12/1/0, with `valid` low for exactly the 16 CALC cycles between them.

Source files
------------

// File: rtl/isqrt_pkg.sv
// isqrt_pkg: shared types and width helpers for the isqrt_engine block.
//   state_e          : controller states (IDLE, CALC, HOLD)
//   ISQRT_DEF_WIDTH  : default operand width
//   ISQRT_DEF_ROOT_W : root width for the default operand width (WIDTH/2)
//   ISQRT_DEF_REM_W  : remainder width for the default operand width (WIDTH/2+1)
//   root_w()/rem_w() : the same helpers for an arbitrary operand width
package isqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int ISQRT_DEF_WIDTH  = 32;
  localparam int ISQRT_DEF_ROOT_W = ISQRT_DEF_WIDTH / 2;
  localparam int ISQRT_DEF_REM_W  = ISQRT_DEF_WIDTH / 2 + 1;

  function automatic int root_w(input int width);
    return width / 2;
  endfunction

  function automatic int rem_w(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/isqrt_step.sv
// isqrt_step: one combinational iteration of the digit-by-digit square root.
//   rem_i  [ROOT_W+1:0] : partial remainder before this iteration
//   root_i [ROOT_W-1:0] : partial root before this iteration
//   pair_i [1:0]        : next operand bit pair, most significant first
//   rem_o  [ROOT_W+1:0] : partial remainder after this iteration
//   root_o [ROOT_W-1:0] : partial root after this iteration
module isqrt_step
  import isqrt_pkg::*;
#(
  parameter int ROOT_W = ISQRT_DEF_ROOT_W
) (
  input  logic [ROOT_W+1:0] rem_i,
  input  logic [ROOT_W-1:0] root_i,
  input  logic [1:0]        pair_i,
  output logic [ROOT_W+1:0] rem_o,
  output logic [ROOT_W-1:0] root_o
);

  localparam int RW2 = ROOT_W + 2;

  logic [RW2-1:0] rem_sh;
  logic [RW2-1:0] trial;
  logic           ge;

  // The bits shifted out of rem/root are always zero because the running
  // remainder never exceeds twice the running root.
  always_comb begin
    rem_sh = RW2'({rem_i, pair_i});
    trial  = RW2'({root_i, 2'b01});
    ge     = (rem_sh >= trial);
    rem_o  = ge ? (rem_sh - trial) : rem_sh;
    root_o = ROOT_W'({root_i, ge});
  end

endmodule

// File: rtl/isqrt_engine.sv
// isqrt_engine: sequential integer square root, one result bit per clock.
//   clk       : rising-edge clock
//   reset     : asynchronous, active-low reset
//   start     : request, sampled only while ready=1
//   operand   : unsigned operand, captured on the accepted start
//   ready     : high in IDLE and HOLD
//   valid     : level, results final and stable
//   root      : floor(sqrt(operand))
//   remainder : operand - root*root
//   is_square : remainder == 0, qualified by valid
// Build option: define ISQRT_EARLY_EXIT_EN to start iterating at the highest
// nonzero operand bit pair (shorter latency, identical results).
module isqrt_engine
  import isqrt_pkg::*;
#(
  parameter int WIDTH = ISQRT_DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   operand,
  output logic               ready,
  output logic               valid,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH/2:0]   remainder,
  output logic               is_square
);

  localparam int RW  = root_w(WIDTH);
  localparam int RMW = rem_w(WIDTH);
  localparam int IW  = (RW > 1) ? $clog2(RW) : 1;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            valid_q, valid_d;
  logic [RW-1:0]   root_q, root_d;
  logic [RMW-1:0]  remainder_q, remainder_d;
  logic            sq_q, sq_d;

  logic [WIDTH-1:0] op_q, op_d;
  logic [RW+1:0]    rem_q, rem_d;
  logic [RW-1:0]    acc_q, acc_d;

  logic [RW+1:0]    step_rem;
  logic [RW-1:0]    step_root;
  logic [1:0]       step_pair;
  logic [IW-1:0]    idx_load;

`ifdef ISQRT_EARLY_EXIT_EN
  // Highest nonzero bit pair of the incoming operand; 0 for a zero operand.
  logic [IW-1:0] lead_idx;
  always_comb begin
    lead_idx = '0;
    for (int p = 0; p < RW; p++) begin
      if (operand[2*p +: 2] != 2'b00) lead_idx = IW'(p);
    end
  end
  assign idx_load = lead_idx;
`else
  assign idx_load = IW'(RW - 1);
`endif

  assign step_pair = op_q[{idx_q, 1'b0} +: 2];

  isqrt_step #(
    .ROOT_W (RW)
  ) u_step (
    .rem_i  (rem_q),
    .root_i (acc_q),
    .pair_i (step_pair),
    .rem_o  (step_rem),
    .root_o (step_root)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    valid_d     = valid_q;
    root_d      = root_q;
    remainder_d = remainder_q;
    sq_d        = sq_q;
    op_d        = op_q;
    rem_d       = rem_q;
    acc_d       = acc_q;
    case (state_q)
      IDLE, HOLD: begin
        if (start) begin
          state_d = CALC;
          op_d    = operand;
          rem_d   = '0;
          acc_d   = '0;
          idx_d   = idx_load;
          valid_d = 1'b0;
        end
      end
      CALC: begin
        rem_d = step_rem;
        acc_d = step_root;
        if (idx_q == '0) begin
          // Final pair: publish results only now so outputs never show partials.
          state_d     = HOLD;
          valid_d     = 1'b1;
          root_d      = step_root;
          remainder_d = RMW'(step_rem);
          sq_d        = (step_rem == '0);
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      valid_q     <= 1'b0;
      root_q      <= '0;
      remainder_q <= '0;
      sq_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      valid_q     <= valid_d;
      root_q      <= root_d;
      remainder_q <= remainder_d;
      sq_q        <= sq_d;
    end
  end

  // Working registers are always reloaded on an accepted start.
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    rem_q <= rem_d;
    acc_q <= acc_d;
  end

  assign ready     = (state_q != CALC);
  assign valid     = valid_q;
  assign root      = root_q;
  assign remainder = remainder_q;
  assign is_square = sq_q & valid_q;

endmodule
